// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects plus stall, bubble and flush
// sequencing for load-use hazards, taken redirects and multi-cycle ALU operations.
module ex_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int MC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] FeDe_src1,
    input  logic [REG_AW-1:0] FeDe_src2,
    input  logic              FeDe_src1_vld,
    input  logic              FeDe_src2_vld,
    input  logic [REG_AW-1:0] DeEx_src1,
    input  logic [REG_AW-1:0] DeEx_src2,
    input  logic [REG_AW-1:0] DeEx_dst,
    input  logic              DeEx_reg_wrt_en,
    input  logic              DeEx_mem_en,
    input  logic              DeEx_mem_wrt,
    input  logic [4:0]        DeEx_ALU_op,
    input  logic [REG_AW-1:0] ExMe_dst,
    input  logic              ExMe_reg_wrt_en,
    input  logic [REG_AW-1:0] MeWb_dst,
    input  logic              MeWb_reg_wrt_en,
    input  logic              ex_redirect,
    output logic [1:0]        forward1_sel,
    output logic [1:0]        forward2_sel,
    output logic              pc_hold,
    output logic              FeDe_hold,
    output logic              FeDe_flush,
    output logic              DeEx_hold,
    output logic              DeEx_flush,
    output logic              ExMe_bubble,
    output logic              mc_busy
);

    // state   | meaning
    // RUN     | normal flow; a multi-cycle op in DeEx holds combinationally and enters MC_BUSY
    // MC_BUSY | multi-cycle op occupying execute; counter holds remaining cycles
    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

    localparam int CNT_W = $clog2(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic isLoad;
    logic loadUse;
    logic mcHold;
    logic luStall;

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] exDst,
        input logic              exWe,
        input logic [REG_AW-1:0] wbDst,
        input logic              wbWe
    );
        if (exWe && exDst == src)
            return 2'b01;
        else if (wbWe && wbDst == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign isLoad  = DeEx_mem_en & ~DeEx_mem_wrt & DeEx_reg_wrt_en;
    assign loadUse = isLoad & ((FeDe_src1_vld & (FeDe_src1 == DeEx_dst)) |
                               (FeDe_src2_vld & (FeDe_src2 == DeEx_dst)));

    // Redirect outranks the multi-cycle hold, which outranks the load-use stall.
    assign mcHold  = ~ex_redirect & ((state == MC_BUSY) | DeEx_ALU_op[4]);
    assign luStall = ~ex_redirect & ~mcHold & loadUse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (DeEx_ALU_op[4] && !ex_redirect) begin
                state <= MC_BUSY;
                cnt   <= CNT_LOAD;
            end
        end else begin
            if (ex_redirect || cnt <= CNT_W'(1)) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Outputs are forced quiet while reset is held so an aborted op leaves no hold behind.
    always_comb begin
        forward1_sel = 2'b00;
        forward2_sel = 2'b00;
        pc_hold      = 1'b0;
        FeDe_hold    = 1'b0;
        FeDe_flush   = 1'b0;
        DeEx_hold    = 1'b0;
        DeEx_flush   = 1'b0;
        ExMe_bubble  = 1'b0;
        mc_busy      = 1'b0;
        if (!rst) begin
            forward1_sel = fwdSel(DeEx_src1, ExMe_dst, ExMe_reg_wrt_en, MeWb_dst, MeWb_reg_wrt_en);
            forward2_sel = fwdSel(DeEx_src2, ExMe_dst, ExMe_reg_wrt_en, MeWb_dst, MeWb_reg_wrt_en);
            pc_hold      = mcHold | luStall;
            FeDe_hold    = mcHold | luStall;
            FeDe_flush   = ex_redirect;
            DeEx_hold    = mcHold;
            DeEx_flush   = ex_redirect | luStall;
            ExMe_bubble  = mcHold;
            mc_busy      = mcHold;
        end
    end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the execute stage. Generates the two execute-operand forwarding selects and sequences pipeline stalls, bubbles and flushes for load-use hazards, taken branches/jumps, and multi-cycle ALU operations (ALU op codes with bit 4 set). It sits beside the decode/execute/memory pipeline registers and drives their hold and clear controls together with the PC hold.

## Interface
Parameters:
- REG_AW, 5, register-address width
- MC_CYCLES, 4, total execute-stage cycles for a multi-cycle ALU op (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- FeDe_src1, FeDe_src2  in  REG_AW  source registers of the instruction in decode
- FeDe_src1_vld, FeDe_src2_vld  in  1  decode instruction actually reads that source
- DeEx_src1, DeEx_src2  in  REG_AW  source registers of the instruction in execute
- DeEx_dst  in  REG_AW  destination of the execute instruction
- DeEx_reg_wrt_en, DeEx_mem_en, DeEx_mem_wrt  in  1  execute-instruction controls; load = mem_en & !mem_wrt
- DeEx_ALU_op  in  5  execute ALU op; bit 4 = multi-cycle op
- ExMe_dst, ExMe_reg_wrt_en  in  REG_AW/1  memory-stage destination and write enable
- MeWb_dst, MeWb_reg_wrt_en  in  REG_AW/1  writeback-stage destination and write enable
- ex_redirect  in  1  execute resolved a taken branch or jump this cycle
- forward1_sel, forward2_sel  out  2  00 register file, 01 ExMe ALU result, 10 writeback data; 11 never driven
- pc_hold  out  1  PC keeps its value
- FeDe_hold  out  1  decode pipeline register keeps its value
- FeDe_flush  out  1  decode pipeline register loads a bubble
- DeEx_hold  out  1  execute pipeline register keeps its value
- DeEx_flush  out  1  execute pipeline register loads a bubble
- ExMe_bubble  out  1  memory pipeline register loads a bubble
- mc_busy  out  1  multi-cycle op in progress

## Operation
- Register 0 is ordinary; no hardwired-zero special case.
- Forwarding (combinational): for source n, ExMe match (ExMe_reg_wrt_en & ExMe_dst==DeEx_srcn) gives 01; otherwise MeWb match gives 10; otherwise 00. ExMe takes priority when both match.
- Load-use hazard: DeEx is a load with DeEx_reg_wrt_en, and a valid FeDe source equals DeEx_dst. Response for one cycle: pc_hold=1, FeDe_hold=1, DeEx_flush=1. The dependent instruction later receives forward select 10.
- Multi-cycle op: FSM states RUN, MC_BUSY.
  - RUN: if DeEx_ALU_op[4]=1 and ex_redirect=0, load counter with MC_CYCLES-1 and move to MC_BUSY. In this first cycle assert pc_hold, FeDe_hold, DeEx_hold and ExMe_bubble.
  - MC_BUSY: keep asserting the same four signals and decrement the counter each cycle. When the counter reaches 1, the next state is RUN and the holds deassert, so the op advances on that edge. Total occupancy is exactly MC_CYCLES cycles.
  - mc_busy=1 on every cycle where these holds are asserted.
- Redirect: ex_redirect=1 asserts FeDe_flush=1 and DeEx_flush=1 in the same cycle and clears all holds. The PC loads the target.
- Priority: redirect > multi-cycle hold > load-use stall.
  - A load-use hazard detected during MC_BUSY is suppressed; it is re-evaluated in RUN.
  - Redirect is never asserted during MC_BUSY, because the op in execute is not a branch. If it is asserted anyway, it forces RUN, clears the counter and flushes.
- Hold and flush on the same register are never both 1.

## Timing
- Forwarding selects, load-use outputs and redirect outputs are combinational from inputs in the same cycle. Multi-cycle holds combine the state with the current op.
- State and counter are the only flops: state is 1 bit; the counter is ceil(log2(MC_CYCLES)) bits and saturates at 0.
- Reset (asynchronous, while rst=1 and immediately after release): state=RUN, counter=0, and all outputs 0 (forward sels 00). Reset during MC_BUSY aborts the op with no pending hold.
- Back-to-back multi-cycle ops: after returning to RUN, a new op in DeEx re-enters MC_BUSY on the next cycle with no idle gap required.

## Test plan
- Forwarding: DeEx_src1=3, ExMe_dst=3 and MeWb_dst=3, both write enables 1 -> forward1_sel=01. Drop ExMe_reg_wrt_en -> forward1_sel=10. No matches -> 00.
- Load-use: DeEx load with dst=5, FeDe_src2=5, src2_vld=1 -> pc_hold=FeDe_hold=DeEx_flush=1 for exactly 1 cycle. Two cycles later forward2_sel=10.
- Multi-cycle: MC_CYCLES=4 and DeEx_ALU_op=5'b10010 -> holds, ExMe_bubble and mc_busy=1 for 4 consecutive cycles, then 0. Repeat with a second op immediately after -> another 4 cycles.
- Redirect priority: ex_redirect=1 together with a load-use hazard -> FeDe_flush=DeEx_flush=1, pc_hold=0, FeDe_hold=0.
- Suppression: load-use condition present during MC_BUSY -> only the multi-cycle holds are asserted and DeEx_flush=0.
- Async reset: assert rst in the 2nd MC_BUSY cycle, off a clock edge -> all outputs 0 immediately. After release, mc_busy=0 until a new op arrives.
